// File: rtl/lockin_pkg.sv
// Shared widths and FSM encoding for the lock-in demodulator.
package lockin_pkg;
   localparam int LOCKIN_DATA_W     = 24;
   localparam int LOCKIN_LUT_BITS   = 18;
   localparam int LOCKIN_LUT_DEPTH  = 10;
   localparam int LOCKIN_PHASE_W    = 32;
   localparam int LOCKIN_N_LOG2_MAX = 16;
   localparam int LOCKIN_OUT_W      = LOCKIN_DATA_W + LOCKIN_LUT_BITS;
   localparam int LOCKIN_ACC_W      = LOCKIN_OUT_W + LOCKIN_N_LOG2_MAX;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } lockin_state_e;
endpackage

// File: rtl/lockin_demodulator_if.sv
// Control, sample stream and I/Q result signals of the lock-in demodulator.
interface lockin_demodulator_if
   import lockin_pkg::*;
#(
   parameter int DATA_W  = LOCKIN_DATA_W,
   parameter int PHASE_W = LOCKIN_PHASE_W,
   parameter int OUT_W   = LOCKIN_OUT_W
);
   logic                      start;
   logic [PHASE_W-1:0]        tuning_word;
   logic [4:0]                n_log2;
   logic signed [DATA_W-1:0]  sample_in;
   logic                      sample_valid;
   logic signed [OUT_W-1:0]   i_out;
   logic signed [OUT_W-1:0]   q_out;
   logic                      out_valid;
   logic                      busy;

   modport master (
      output start, tuning_word, n_log2, sample_in, sample_valid,
      input  i_out, q_out, out_valid, busy
   );

   modport slave (
      input  start, tuning_word, n_log2, sample_in, sample_valid,
      output i_out, q_out, out_valid, busy
   );
endinterface

// File: rtl/lockin_phase_acc.sv
// Phase accumulator: latches the tuning word on clear, steps once per
// accepted sample, and exposes the top phase bits as the LUT address.
module lockin_phase_acc
   import lockin_pkg::*;
#(
   parameter int PHASE_W   = LOCKIN_PHASE_W,
   parameter int LUT_DEPTH = LOCKIN_LUT_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [PHASE_W-1:0]   tuning_word,
   output logic [LUT_DEPTH-1:0] lut_addr
);
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [PHASE_W-1:0] tw_q, tw_d;

   // Next phase: restart at zero with a fresh tuning word, else advance on accept.
   always_comb begin
      phase_d = phase_q;
      tw_d    = tw_q;
      if (clear) begin
         phase_d = '0;
         tw_d    = tuning_word;
      end else if (enable) begin
         phase_d = phase_q + tw_q;
      end
   end

   // Phase and latched tuning word registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
         tw_q    <= '0;
      end else begin
         phase_q <= phase_d;
         tw_q    <= tw_d;
      end
   end

   assign lut_addr = phase_q[PHASE_W-1 -: LUT_DEPTH];
endmodule

// File: rtl/lockin_demodulator.sv
// Lock-in demodulator: mixes each accepted sample with the LUT sine/cosine,
// integrates 2^n_eff products and emits the arithmetic-shift average.
module lockin_demodulator
   import lockin_pkg::*;
#(
   parameter int DATA_W     = LOCKIN_DATA_W,
   parameter int LUT_DEPTH  = LOCKIN_LUT_DEPTH,
   parameter int LUT_BITS   = LOCKIN_LUT_BITS,
   parameter int PHASE_W    = LOCKIN_PHASE_W,
   parameter int N_LOG2_MAX = LOCKIN_N_LOG2_MAX,
   parameter int OUT_W      = DATA_W + LUT_BITS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   lockin_demodulator_if.slave        bus,
   output logic [LUT_DEPTH-1:0]       lut_addr,
   input  logic signed [LUT_BITS-1:0] lut_sine,
   input  logic signed [LUT_BITS-1:0] lut_cosine
);
   localparam int ACC_W = OUT_W + N_LOG2_MAX;
   localparam int CNT_W = N_LOG2_MAX + 1;

   lockin_state_e            state_q, state_d;
   logic [4:0]               n_eff_q, n_eff_d;
   logic [CNT_W-1:0]         count_q, count_d, target;
   logic                     accept, clear, fire;
   logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
   logic signed [DATA_W-1:0] sample_p1_q, sample_p1_d;
   logic signed [OUT_W-1:0]  prod_i_p2_q, prod_i_p2_d, prod_q_p2_q, prod_q_p2_d;
   logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic signed [OUT_W-1:0]  i_out_q, i_out_d, q_out_q, q_out_d;
   logic                     out_valid_q, out_valid_d;

   function automatic logic [4:0] clamp_n(input logic [4:0] n);
      return (n > 5'(N_LOG2_MAX)) ? 5'(N_LOG2_MAX) : n;
   endfunction

   // Averaging is a plain arithmetic shift: truncation toward -inf, low OUT_W bits kept.
   function automatic logic signed [OUT_W-1:0] avg_shift(input logic signed [ACC_W-1:0] acc,
                                                         input logic [4:0] n);
      logic signed [ACC_W-1:0] sh;
      sh = acc >>> n;
      return sh[OUT_W-1:0];
   endfunction

   assign clear  = (state_q == ST_IDLE) && bus.start;
   assign accept = (state_q == ST_RUN) && bus.sample_valid;
   assign target = CNT_W'(1) << n_eff_q;

   lockin_phase_acc #(
      .PHASE_W   (PHASE_W),
      .LUT_DEPTH (LUT_DEPTH)
   ) u_phase_acc (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .enable      (accept),
      .tuning_word (bus.tuning_word),
      .lut_addr    (lut_addr)
   );

   // FSM next state: sample counting in RUN, wait for the pipeline to empty in DRAIN.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      n_eff_d = n_eff_q;
      fire    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               n_eff_d = clamp_n(bus.n_log2);
               count_d = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.sample_valid) begin
               count_d = count_q + CNT_W'(1);
               if (count_d == target) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!vld_p1_q && !vld_p2_q) begin
               fire    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: capture, mix, integrate, publish.
   always_comb begin
      // p1: sample aligned with the LUT read issued on the same edge
      sample_p1_d = bus.sample_in;
      vld_p1_d    = accept;
      // p2: full-precision mixer products
      prod_i_p2_d = OUT_W'(sample_p1_q) * OUT_W'(lut_sine);
      prod_q_p2_d = OUT_W'(sample_p1_q) * OUT_W'(lut_cosine);
      vld_p2_d    = vld_p1_q;
      // accumulate: sign-extended, wide enough for 2^N_LOG2_MAX products
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
      if (clear) begin
         acc_i_d = '0;
         acc_q_d = '0;
      end else if (vld_p2_q) begin
         acc_i_d = acc_i_q + ACC_W'(prod_i_p2_q);
         acc_q_d = acc_q_q + ACC_W'(prod_q_p2_q);
      end
      // result: hold until the next completed integration
      i_out_d     = fire ? avg_shift(acc_i_q, n_eff_q) : i_out_q;
      q_out_d     = fire ? avg_shift(acc_q_q, n_eff_q) : q_out_q;
      out_valid_d = fire;
   end

   // Control, accumulator and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         n_eff_q     <= '0;
         vld_p1_q    <= 1'b0;
         vld_p2_q    <= 1'b0;
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         i_out_q     <= '0;
         q_out_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         n_eff_q     <= n_eff_d;
         vld_p1_q    <= vld_p1_d;
         vld_p2_q    <= vld_p2_d;
         acc_i_q     <= acc_i_d;
         acc_q_q     <= acc_q_d;
         i_out_q     <= i_out_d;
         q_out_q     <= q_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Pipeline data registers; qualified by the valids, so no reset needed.
   always_ff @(posedge clk) begin
      sample_p1_q <= sample_p1_d;
      prod_i_p2_q <= prod_i_p2_d;
      prod_q_p2_q <= prod_q_p2_d;
   end

   assign bus.i_out     = i_out_q;
   assign bus.q_out     = q_out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_lockin_demodulator.sv
// Self-checking bench for lockin_demodulator with a behavioural LUT model.
module tb_lockin_demodulator;
   import lockin_pkg::*;

   localparam int DATA_W     = 24;
   localparam int LUT_DEPTH  = 10;
   localparam int LUT_BITS   = 18;
   localparam int PHASE_W    = 32;
   localparam int N_LOG2_MAX = 16;
   localparam int OUT_W      = DATA_W + LUT_BITS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lockin_demodulator_if #(.DATA_W(DATA_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus ();

   logic [LUT_DEPTH-1:0]       lut_addr;
   logic signed [LUT_BITS-1:0] lut_sine, lut_cosine;

   lockin_demodulator #(
      .DATA_W(DATA_W), .LUT_DEPTH(LUT_DEPTH), .LUT_BITS(LUT_BITS),
      .PHASE_W(PHASE_W), .N_LOG2_MAX(N_LOG2_MAX), .OUT_W(OUT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .lut_addr   (lut_addr),
      .lut_sine   (lut_sine),
      .lut_cosine (lut_cosine)
   );

   // Quarter-wave exact points: 0 -> 0/131071, 256 -> 131071/0, 512 -> 0/-131071, 768 -> -131071/0
   function automatic int lut_sin_val(input logic [LUT_DEPTH-1:0] a);
      real x;
      x = 131071.0 * $sin(2.0 * 3.14159265358979 * real'(a) / 1024.0);
      return int'(x);
   endfunction
   function automatic int lut_cos_val(input logic [LUT_DEPTH-1:0] a);
      real x;
      x = 131071.0 * $cos(2.0 * 3.14159265358979 * real'(a) / 1024.0);
      return int'(x);
   endfunction

   // Registered LUT, one cycle of latency like the real DDFS table.
   always @(posedge clk) begin
      lut_sine   <= LUT_BITS'(lut_sin_val(lut_addr));
      lut_cosine <= LUT_BITS'(lut_cos_val(lut_addr));
   end

   typedef struct {
      logic signed [OUT_W-1:0] i;
      logic signed [OUT_W-1:0] q;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every out_valid pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", longint'(bus.out_valid), 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("i_out", longint'(bus.i_out), longint'(e.i));
            chk("q_out", longint'(bus.q_out), longint'(e.q));
            chk("latency", longint'(cyc - last_acc_cyc), 3);
            chk("busy_with_out_valid", longint'(bus.busy), 0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 300) begin
         step();
         n++;
      end
      if (bus.busy) chk("idle_timeout", longint'(bus.busy), 0);
   endtask

   // Reference: average of sample*sin/cos at phase k*tw over 2^n_eff samples.
   task automatic run_job(input logic [31:0] tw, input int n, input int smp[$],
                          input int gap, input bit disturb);
      exp_t e;
      longint si, sq;
      int neff, cnt, g;
      logic [31:0] ph;
      neff = (n > N_LOG2_MAX) ? N_LOG2_MAX : n;
      cnt  = 1 << neff;
      si = 0;
      sq = 0;
      for (int k = 0; k < cnt; k++) begin
         ph = 32'(k) * tw;
         si += longint'(smp[k]) * longint'(lut_sin_val(ph[31:22]));
         sq += longint'(smp[k]) * longint'(lut_cos_val(ph[31:22]));
      end
      e.i = OUT_W'(si >>> neff);
      e.q = OUT_W'(sq >>> neff);

      wait_idle();
      exp_q.push_back(e);
      bus.start       = 1'b1;
      bus.tuning_word = tw;
      bus.n_log2      = 5'(n);
      step();
      bus.start = 1'b0;
      for (int k = 0; k < cnt; k++) begin
         if (disturb && k == 5) begin
            bus.start       = 1'b1;
            bus.n_log2      = 5'd8;
            bus.tuning_word = $urandom;
         end
         ph = 32'(k) * tw;
         chk("lut_addr", longint'(lut_addr), longint'(ph[31:22]));
         bus.sample_in    = DATA_W'(smp[k]);
         bus.sample_valid = 1'b1;
         step();
         last_acc_cyc     = cyc;
         bus.sample_valid = 1'b0;
         bus.start        = 1'b0;
         g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
         repeat (g) begin
            bus.sample_in = DATA_W'($urandom);
            step();
         end
      end
      // Samples offered while draining must be ignored.
      if (bus.busy) begin
         bus.sample_in    = DATA_W'($urandom);
         bus.sample_valid = 1'b1;
         step();
         bus.sample_valid = 1'b0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_i_out"}, longint'(bus.i_out), 0);
      chk({tag, "_q_out"}, longint'(bus.q_out), 0);
      chk({tag, "_out_valid"}, longint'(bus.out_valid), 0);
      chk({tag, "_busy"}, longint'(bus.busy), 0);
      chk({tag, "_lut_addr"}, longint'(lut_addr), 0);
   endtask

   initial begin
      int s[$];
      bus.start        = 1'b0;
      bus.tuning_word  = '0;
      bus.n_log2       = '0;
      bus.sample_in    = '0;
      bus.sample_valid = 1'b0;

      repeat (3) step();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      step();

      // DC at zero phase
      s = {};
      repeat (16) s.push_back(1000);
      run_job(32'h0, 4, s, 0, 1'b0);

      // Quarter-step sweep
      s = {0, 1000, 0, -1000};
      run_job(32'h4000_0000, 2, s, 0, 1'b0);

      // Sparse input: valid every third cycle
      s = {};
      repeat (16) s.push_back(1000);
      run_job(32'h0, 4, s, 2, 1'b0);

      // Start and parameter changes while busy are ignored
      run_job(32'h0, 4, s, 0, 1'b1);

      // Reset in the middle of an integration
      wait_idle();
      bus.start       = 1'b1;
      bus.tuning_word = 32'h1234_5678;
      bus.n_log2      = 5'd4;
      step();
      bus.start = 1'b0;
      repeat (7) begin
         bus.sample_in    = DATA_W'($urandom);
         bus.sample_valid = 1'b1;
         step();
      end
      bus.sample_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      check_reset_outputs("midrun_reset");
      repeat (3) step();
      rst_n = 1'b1;
      step();
      run_job(32'h0, 4, s, 0, 1'b0);

      // Single-sample integration
      s = {-5};
      run_job(32'h0, 0, s, 0, 1'b0);

      // Randomized jobs with random gaps
      for (int j = 0; j < 8; j++) begin
         int n;
         n = int'($urandom_range(0, 5));
         s = {};
         repeat (1 << n) s.push_back(int'($signed(DATA_W'($urandom))));
         run_job($urandom, n, s, -1, j[0]);
      end

      wait_idle();
      repeat (5) step();
      chk("expectations_left", longint'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
